// File: rtl/sobel_stream_if.sv
// Stream bundle for sobel_stream: the pixel input beat, the gradient outputs and the FSM state.
interface sobel_stream_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic [DATA_W-1:0] out_mag;
    logic              frame_done;
    logic [1:0]        state;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_x, out_y, out_mag, frame_done, state
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_x, out_y, out_mag, frame_done, state
    );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine: two line buffers, a register window and a 2-stage output pipeline.
// Optional macro SOBEL_THRESH_EN turns out_mag into a binarised edge map against THRESH.
module sobel_stream #(
    parameter int LINE_W = 482,
    parameter int LINE_H = 362,
    parameter int DATA_W = 8,
    parameter int THRESH = 128
) (
    input  logic          clk,
    input  logic          rst,
    sobel_stream_if.slave bus
);
    localparam int CW = $clog2(LINE_W);
    localparam int RW = $clog2(LINE_H);
    localparam int GW = DATA_W + 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [DATA_W-1:0] PIX_MAX = {DATA_W{1'b1}};

    if (LINE_W < 3 || LINE_H < 3 || THRESH < 0) begin : g_cfg_err
        $error("sobel_stream: illegal LINE_W/LINE_H/THRESH");
    end

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              busy_s, accept_s, restart_s, squash_s, win_ok_s, last_beat_s;
    logic [CW-1:0]     pos_col_s;
    logic [RW-1:0]     pos_row_s;
    logic [DATA_W-1:0] lb1_q [LINE_W];
    logic [DATA_W-1:0] lb2_q [LINE_W];
    logic [DATA_W-1:0] w_q [3][3];
    logic signed [GW-1:0] gx_s, gy_s;
    logic [GW-1:0]     abs_x_q, abs_y_q, sum_s;
    logic              v1_q, l1_q, v2_q, l2_q;
    logic              out_valid_q, frame_done_q;
    logic [DATA_W-1:0] out_x_q, out_y_q, out_mag_q, mag_s;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [GW-1:0] absg(input logic signed [GW-1:0] g);
        if (g[GW-1]) begin
            return $unsigned(-g);
        end else begin
            return $unsigned(g);
        end
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [GW-1:0] v);
        if (v > {4'b0000, PIX_MAX}) begin
            return PIX_MAX;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a restart beat always wins and reopens the frame in FILL
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (restart_s) state_d = ST_FILL;
                else           state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (restart_s) state_d = ST_FILL;
                else if (accept_s && row_q == RW'(2) && col_q == CW'(0)) state_d = ST_RUN;
                else           state_d = ST_FILL;
            end
            ST_RUN: begin
                if (restart_s)        state_d = ST_FILL;
                else if (last_beat_s) state_d = ST_DONE;
                else                  state_d = ST_RUN;
            end
            ST_DONE: begin
                if (restart_s)                        state_d = ST_FILL;
                else if (out_valid_q && frame_done_q) state_d = ST_IDLE;
                else                                  state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            ST_FILL, ST_RUN: busy_s = 1'b1;
            default:         busy_s = 1'b0;
        endcase
    end

    // Beat decode: a start-of-frame pixel is position (0,0) whatever the counters say
    always_comb begin
        accept_s  = bus.in_valid && (bus.in_sof || busy_s);
        restart_s = accept_s && bus.in_sof;
        squash_s  = restart_s && busy_s;
        if (bus.in_sof) begin
            pos_col_s = CW'(0);
            pos_row_s = RW'(0);
        end else begin
            pos_col_s = col_q;
            pos_row_s = row_q;
        end
        win_ok_s    = accept_s && (pos_row_s >= RW'(2)) && (pos_col_s >= CW'(2));
        last_beat_s = accept_s && !bus.in_sof && (row_q == RW'(LINE_H-1)) && (col_q == CW'(LINE_W-1));
    end

    // Raster counters
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (restart_s) begin
            col_d = CW'(1);
            row_d = RW'(0);
        end else if (accept_s) begin
            if (col_q == CW'(LINE_W-1)) begin
                col_d = CW'(0);
                if (row_q == RW'(LINE_H-1)) row_d = RW'(0);
                else                        row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= CW'(0);
            row_q <= RW'(0);
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffers and window; contents are always overwritten before they matter
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_q[pos_col_s] <= bus.in_data;
            lb2_q[pos_col_s] <= lb1_q[pos_col_s];
            for (int r = 0; r < 3; r++) begin
                w_q[r][0] <= w_q[r][1];
                w_q[r][1] <= w_q[r][2];
            end
            w_q[0][2] <= lb2_q[pos_col_s];
            w_q[1][2] <= lb1_q[pos_col_s];
            w_q[2][2] <= bus.in_data;
        end
    end

    // Gradients of the current window, then magnitude selection
    always_comb begin
        gx_s = (ext(w_q[0][2]) + (ext(w_q[1][2]) <<< 1) + ext(w_q[2][2]))
             - (ext(w_q[0][0]) + (ext(w_q[1][0]) <<< 1) + ext(w_q[2][0]));
        gy_s = (ext(w_q[2][0]) + (ext(w_q[2][1]) <<< 1) + ext(w_q[2][2]))
             - (ext(w_q[0][0]) + (ext(w_q[0][1]) <<< 1) + ext(w_q[0][2]));
        sum_s = abs_x_q + abs_y_q;
`ifdef SOBEL_THRESH_EN
        if (sum_s >= GW'(THRESH)) mag_s = PIX_MAX;
        else                      mag_s = {DATA_W{1'b0}};
`else
        mag_s = sat(sum_s);
`endif
    end

    // Two-stage result pipeline; a restart kills whatever of the old frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q         <= 1'b0;
            l1_q         <= 1'b0;
            v2_q         <= 1'b0;
            l2_q         <= 1'b0;
            abs_x_q      <= {GW{1'b0}};
            abs_y_q      <= {GW{1'b0}};
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_x_q      <= {DATA_W{1'b0}};
            out_y_q      <= {DATA_W{1'b0}};
            out_mag_q    <= {DATA_W{1'b0}};
        end else begin
            v1_q         <= win_ok_s;
            l1_q         <= last_beat_s;
            v2_q         <= v1_q && !squash_s;
            l2_q         <= l1_q && !squash_s;
            out_valid_q  <= v2_q && !squash_s;
            frame_done_q <= l2_q && !squash_s;
            if (v1_q) begin
                abs_x_q <= absg(gx_s);
                abs_y_q <= absg(gy_s);
            end
            if (v2_q && !squash_s) begin
                out_x_q   <= sat(abs_x_q);
                out_y_q   <= sat(abs_y_q);
                out_mag_q <= mag_s;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_mag    = out_mag_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: table of known frames, restart/reset sequences and random frames vs a model.
module tb_sobel_stream;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int TH = 100;
`ifdef SOBEL_THRESH_EN
    localparam int M80  = 0;
    localparam int M240 = 255;
`else
    localparam int M80  = 80;
    localparam int M240 = 240;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_stream_if #(.DATA_W(DW)) bus_if();
    sobel_stream #(.LINE_W(W), .LINE_H(H), .DATA_W(DW), .THRESH(TH)) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );

    typedef struct { int due; int x; int y; int m; bit last; } exp_t;
    typedef struct { int pat; int gap; int x0; int x1; int x2; int y; int m0; int m1; int m2; } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    exp_t expq[$];
    int cap_x[$];
    int cap_y[$];
    int cap_m[$];
    int img[H][W];
    vec_t vt[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int mag_ref(input int ax, input int ay);
`ifdef SOBEL_THRESH_EN
        return (ax + ay >= TH) ? 255 : 0;
`else
        return sat8(ax + ay);
`endif
    endfunction

    // Output monitor: every valid output is matched in order against the model queue
    initial begin
        int hx, hy, hm;
        exp_t e;
        hx = 0; hy = 0; hm = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hx = 0; hy = 0; hm = 0;
            end else if (bus_if.out_valid) begin
                cap_x.push_back(int'(bus_if.out_x));
                cap_y.push_back(int'(bus_if.out_y));
                cap_m.push_back(int'(bus_if.out_mag));
                if (bus_if.frame_done) done_cnt++;
                if (expq.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("out_cycle", cyc, e.due);
                    check("out_x", int'(bus_if.out_x), e.x);
                    check("out_y", int'(bus_if.out_y), e.y);
                    check("out_mag", int'(bus_if.out_mag), e.m);
                    check("frame_done", int'(bus_if.frame_done), int'(e.last));
                end
                hx = int'(bus_if.out_x); hy = int'(bus_if.out_y); hm = int'(bus_if.out_mag);
            end else begin
                check("hold", int'({bus_if.out_x, bus_if.out_y, bus_if.out_mag, bus_if.frame_done}),
                      (hx << 17) | (hy << 9) | (hm << 1));
                if (expq.size() != 0 && expq[0].due < cyc) begin
                    check("missing_out", 0, 1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    // Drives one frame (optionally stopping before pixel stop_r,stop_c) and feeds the model
    task automatic drive_frame(input int pat, input int gap, input int stop_r, input int stop_c,
                               input bit abort_prev);
        int gx, gy, n;
        exp_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0: img[r][c] = 50;
                    1: img[r][c] = (c < 2) ? 0 : 100;
                    2: img[r][c] = 10 * r;
                    3: img[r][c] = 30 * r;
                    4: img[r][c] = $urandom_range(0, 255);
                    default: img[r][c] = 0;
                endcase
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) begin
                    bus_if.in_valid = 1'b0;
                    bus_if.in_sof = 1'b0;
                    return;
                end
                bus_if.in_valid = 1'b1;
                bus_if.in_sof = (r == 0 && c == 0);
                bus_if.in_data = 8'(img[r][c]);
                @(posedge clk); #1;
                if (r == 0 && c == 0) begin
                    if (abort_prev)
                        for (int i = expq.size() - 1; i >= 0; i--)
                            if (expq[i].due >= cyc) expq.delete(i);
                    check("state_fill", int'(bus_if.state), 2);
                end
                if (r == 2 && c == 0) check("state_run", int'(bus_if.state), 1);
                if (r == H - 1 && c == W - 1) check("state_done", int'(bus_if.state), 3);
                if (r >= 2 && c >= 2) begin
                    gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
                       - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
                    gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
                       - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
                    e.due = cyc + 2;
                    e.x = sat8(iabs(gx));
                    e.y = sat8(iabs(gy));
                    e.m = mag_ref(iabs(gx), iabs(gy));
                    e.last = (r == H - 1 && c == W - 1);
                    expq.push_back(e);
                end
                n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (n) begin
                    bus_if.in_valid = 1'b0;
                    bus_if.in_sof = 1'($urandom_range(0, 1));
                    bus_if.in_data = 8'($urandom_range(0, 255));
                    @(posedge clk); #1;
                end
            end
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_sof = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        if (expq.size() != 0) begin
            check("drain_timeout", expq.size(), 0);
            expq.delete();
        end
    endtask

    task automatic clear_cap();
        cap_x.delete(); cap_y.delete(); cap_m.delete();
        done_cnt = 0;
    endtask

    initial begin
        int xe, me;
        vt[0] = '{pat: 0, gap: 0, x0: 0,   x1: 0,   x2: 0, y: 0,   m0: 0,    m1: 0,    m2: 0};
        vt[1] = '{pat: 1, gap: 0, x0: 255, x1: 255, x2: 0, y: 0,   m0: 255,  m1: 255,  m2: 0};
        vt[2] = '{pat: 2, gap: 0, x0: 0,   x1: 0,   x2: 0, y: 80,  m0: M80,  m1: M80,  m2: M80};
        vt[3] = '{pat: 2, gap: 1, x0: 0,   x1: 0,   x2: 0, y: 80,  m0: M80,  m1: M80,  m2: M80};
        vt[4] = '{pat: 3, gap: 0, x0: 0,   x1: 0,   x2: 0, y: 240, m0: M240, m1: M240, m2: M240};

        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_sof = 1'b0;
        bus_if.in_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(bus_if.state), 0);
        check("rst_outs", int'({bus_if.out_valid, bus_if.frame_done, bus_if.out_x, bus_if.out_y, bus_if.out_mag}), 0);
        rst = 1'b0;

        // beats without in_sof while idle are dropped
        repeat (4) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        check("idle_drop_state", int'(bus_if.state), 0);

        for (int i = 0; i < 5; i++) begin
            clear_cap();
            drive_frame(vt[i].pat, vt[i].gap, -1, -1, 1'b0);
            drain();
            check("tbl_count", cap_x.size(), 6);
            check("tbl_done_cnt", done_cnt, 1);
            check("tbl_idle", int'(bus_if.state), 0);
            for (int k = 0; k < cap_x.size() && k < 6; k++) begin
                xe = (k % 3 == 0) ? vt[i].x0 : (k % 3 == 1) ? vt[i].x1 : vt[i].x2;
                me = (k % 3 == 0) ? vt[i].m0 : (k % 3 == 1) ? vt[i].m1 : vt[i].m2;
                check("tbl_x", cap_x[k], xe);
                check("tbl_y", cap_y[k], vt[i].y);
                check("tbl_mag", cap_m[k], me);
            end
        end

        // restart at row 2, col 3 of a frame, followed by a zero frame
        clear_cap();
        drive_frame(4, 0, 2, 3, 1'b0);
        drive_frame(5, 0, -1, -1, 1'b1);
        drain();
        check("abort_count", cap_x.size(), 6);
        check("abort_done_cnt", done_cnt, 1);

        // back-to-back frames: new in_sof right after the final beat
        clear_cap();
        drive_frame(4, 0, -1, -1, 1'b0);
        drive_frame(4, 0, -1, -1, 1'b0);
        drain();
        check("b2b_count", cap_x.size(), 12);
        check("b2b_done_cnt", done_cnt, 2);

        // reset in the middle of RUN with outputs in flight
        drive_frame(4, 0, 3, 1, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_state", int'(bus_if.state), 0);
        check("midrst_outs", int'({bus_if.out_valid, bus_if.frame_done, bus_if.out_x, bus_if.out_y, bus_if.out_mag}), 0);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_cap();
        drive_frame(2, 0, -1, -1, 1'b0);
        drain();
        check("postrst_count", cap_x.size(), 6);
        check("postrst_done_cnt", done_cnt, 1);

        // random frames with random input gaps
        for (int f = 0; f < 4; f++) begin
            clear_cap();
            drive_frame(4, 2, -1, -1, 1'b0);
            drain();
            check("rnd_count", cap_x.size(), 6);
            check("rnd_done_cnt", done_cnt, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
